alu_execute_unit: RTL
=====================

ALU_EXECUTE_UNIT -- requirements
Module: alu_execute_unit

Interface
REQ-001 Parameter: DATA_W, default 24, operand/result width; matches register-file data width.
REQ-002 Parameter: ADDR_W, default 5, register address width; matches register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 MUL, 9 PASSB; 10-15 illegal.
REQ-007 data_reg_1  input  DATA_W  operand A, from register file read port 1.
REQ-008 data_reg_2  input  DATA_W  operand B, from register file read port 2.
REQ-009 dest_reg  input  ADDR_W  destination register for the result.
REQ-010 busy  output  1  high from the cycle after an accepted start through the writeback cycle inclusive.
REQ-011 done  output  1  one-cycle pulse in the writeback cycle.
REQ-012 err  output  1  one-cycle pulse with done when op was illegal.
REQ-013 reg_write  output  1  register-file write enable; one-cycle pulse in writeback.
REQ-014 write_reg  output  ADDR_W  latched dest_reg, driven to the register file.
REQ-015 write_data  output  DATA_W  result, driven to the register file.
REQ-016 zero  output  1  high when last completed result == 0; held until next writeback.

Function
REQ-017 States: IDLE, EXEC, MUL, WB; encoding free.
REQ-018 IDLE: start=1 at edge -> latch A, B, op, dest_reg; go EXEC (op 0-7, 9, illegal) or MUL (op 8).
REQ-019 start while not IDLE shall be ignored; no queuing.
REQ-020 EXEC: compute result into internal register in one cycle; next state WB.
REQ-021 ADD/SUB: modulo 2^DATA_W, carry/borrow discarded.
REQ-022 SLT: signed two's-complement compare, result 1 if A<B else 0.
REQ-023 SLL/SRL: shift A by B[4:0], logical; shift amount >= DATA_W gives 0.
REQ-024 PASSB: result = B.
REQ-025 MUL: iterative shift-add, one multiplier bit per cycle, exactly DATA_W cycles in MUL; result = low DATA_W bits of A*B (unsigned); next state WB.
REQ-026 Latency: start sampled at edge N -> WB cycle is N+2 for single-cycle ops, N+1+DATA_W (N+25) for MUL.
REQ-027 WB: done=1, reg_write=1, write_reg=latched dest, write_data=result for exactly one cycle; next state IDLE.
REQ-028 Illegal op: WB cycle has done=1, err=1, reg_write=0, write_data=0, zero unchanged.
REQ-029 write_reg and write_data shall hold their last values outside WB; only reg_write gates the write.
REQ-030 dest_reg 0 is an ordinary destination; no special casing.
REQ-031 Operands change on data_reg_1/2 after acceptance shall not affect the result.
REQ-032 Back-to-back: start may be accepted in the cycle immediately after WB (IDLE); minimum issue interval 3 cycles.

Reset
REQ-033 rst_n low shall immediately force state IDLE and busy, done, err, reg_write, zero, write_reg, write_data, and all internal registers to 0.
REQ-034 Reset mid-EXEC or mid-MUL shall abort with no writeback pulse after release.
REQ-035 After rst_n rises, first start is accepted at the first rising edge with start=1.

Verification
REQ-036 A=123, B=5, op ADD, dest 3, start at edge N -> edge N+2 cycle: reg_write=1, write_reg=3, write_data=128, done=1, zero=0.
REQ-037 A=5, B=5, op SUB -> write_data=0, zero=1; then A=0x800000, B=1, op SLT -> write_data=1.
REQ-038 A=1000, B=3000, op MUL -> busy high 25 cycles, write_data=0x2DC6C0 (3,000,000) at N+25; A=0xFFFFFF, B=2 -> 0xFFFFFE.
REQ-039 A=0x000001, B=24, op SLL -> 0; B=23 -> 0x800000; op SRL A=0x800000, B=4 -> 0x080000.
REQ-040 op 12 -> done=1, err=1, reg_write=0; start pulsed while busy during MUL -> ignored, single writeback only.
REQ-041 rst_n low at MUL cycle 10 -> all outputs 0 immediately, no reg_write after release; next ADD 2+2 -> 4 with normal latency.

Source files
------------

// File: rtl/alu_execute_unit.sv
// Multi-cycle ALU execute stage: latches operands on start, runs single-cycle ops or an
// iterative shift-add multiply, then pulses a register-file writeback.
module alu_execute_unit #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] data_reg_1,
    input  logic [DATA_W-1:0] data_reg_2,
    input  logic [ADDR_W-1:0] dest_reg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              zero
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SRL   = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] dest_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mul_step;
    logic [4:0]        shamt;
    logic              op_illegal;

    always_comb begin
        shamt      = b_q[4:0];
        op_illegal = (op_q > OP_PASSB);
        // During MUL, a_q is the left-shifting multiplicand and b_q the right-shifting multiplier.
        mul_step   = acc_q + (b_q[0] ? a_q : '0);
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:   alu_res = a_q + b_q;
            OP_SUB:   alu_res = a_q - b_q;
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_SLT:   alu_res[0] = ($signed(a_q) < $signed(b_q));
            OP_SLL:   alu_res = (32'(shamt) >= DATA_W) ? '0 : (a_q << shamt);
            OP_SRL:   alu_res = (32'(shamt) >= DATA_W) ? '0 : (a_q >> shamt);
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            cnt_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            zero       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= data_reg_1;
                        b_q     <= data_reg_2;
                        op_q    <= op;
                        dest_q  <= dest_reg;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= (op == OP_MUL) ? StMul : StExec;
                    end
                end
                StExec: begin
                    state_q   <= StWb;
                    done      <= 1'b1;
                    write_reg <= dest_q;
                    if (op_illegal) begin
                        err        <= 1'b1;
                        write_data <= '0;
                    end else begin
                        reg_write  <= 1'b1;
                        write_data <= alu_res;
                        zero       <= (alu_res == '0);
                    end
                end
                StMul: begin
                    acc_q <= mul_step;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= StWb;
                        done       <= 1'b1;
                        reg_write  <= 1'b1;
                        write_reg  <= dest_q;
                        write_data <= mul_step;
                        zero       <= (mul_step == '0);
                    end
                end
                StWb: begin
                    state_q   <= StIdle;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    reg_write <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
